// File: rtl/div_w_ctrl.sv
// div_w_ctrl: sequencing stage in front of the 64-bit combinational divider for RV64M word divides.
//   Latches and extends DIVW/DIVUW/REMW/REMUW operands, holds the divider inputs for DIV_LATENCY
//   cycles, then captures quotient/remainder, applies divide-by-zero and overflow semantics and
//   sign-extends the 32-bit result.
// Ports:
//   clk, rst (async, active-high)
//   start_in, op_in[1:0], rs1_in[63:0], rs2_in[63:0], flush_in   - request from the core
//   busy_out, done_out, result_out[63:0]                          - stall, result-valid pulse, result
//   div_dividend_out[63:0], div_divisor_out[31:0], div_signed_out - to the divider
//   div_quotient_in[31:0], div_remainder_in[63:0], div_zero_in    - from the divider
// Optional: define DIV_ZERO_FAST_EN to resolve a zero divisor in the issue cycle, bypassing BUSY.
module div_w_ctrl #(
    parameter int DIV_LATENCY = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [63:0] rs1_in,
    input  logic [63:0] rs2_in,
    input  logic        flush_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [63:0] result_out,
    output logic [63:0] div_dividend_out,
    output logic [31:0] div_divisor_out,
    output logic        div_signed_out,
    input  logic [31:0] div_quotient_in,
    input  logic [63:0] div_remainder_in,
    input  logic        div_zero_in
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       dividend_q, dividend_d;
    logic [31:0]       divisor_q, divisor_d;
    logic              signed_q, signed_d;
    logic              is_rem_q, is_rem_d;
    logic [63:0]       result_q, result_d;
    logic              accept, fast, expire, ovf, acc_signed;
    logic [31:0]       quot, rem, sel, fast_sel;
    logic              unused;
    // Upper operand halves and upper remainder bits are irrelevant for W ops.
    assign unused = ^{rs1_in[63:32], rs2_in[63:32], div_remainder_in[63:32]};
    assign accept     = (state_q == IDLE) & start_in & ~flush_in;
    assign expire     = (state_q == BUSY) & (cnt_q == '0) & ~flush_in;
    assign acc_signed = ~op_in[0];
`ifdef DIV_ZERO_FAST_EN
    assign fast = accept & (rs2_in[31:0] == 32'd0);
`else
    assign fast = 1'b0;
`endif
    // Most-negative / -1 cannot be represented by the divider's quotient; RISC-V defines the result.
    assign ovf  = signed_q & (dividend_q[31:0] == 32'h8000_0000) & (divisor_q == 32'hFFFF_FFFF);
    assign quot = div_zero_in ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : div_quotient_in;
    assign rem  = div_zero_in ? dividend_q[31:0] : ovf ? 32'd0 : div_remainder_in[31:0];
    assign sel  = is_rem_q ? rem : quot;
    // Zero-divisor result straight from the request, used only by the fast path.
    assign fast_sel = op_in[1] ? rs1_in[31:0] : 32'hFFFF_FFFF;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            is_rem_q   <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            is_rem_q   <= is_rem_d;
            result_q   <= result_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (fast ? DONE : BUSY) : IDLE;
            BUSY:    state_d = flush_in ? IDLE : (cnt_q == '0) ? DONE : BUSY;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        is_rem_d   = is_rem_q;
        result_d   = result_q;
        if (accept) begin
            signed_d   = acc_signed;
            dividend_d = {{32{acc_signed & rs1_in[31]}}, rs1_in[31:0]};
            divisor_d  = rs2_in[31:0];
            is_rem_d   = op_in[1];
            cnt_d      = CNT_W'(DIV_LATENCY - 1);
        end
        if (fast)
            result_d = {{32{fast_sel[31]}}, fast_sel};
        if ((state_q == BUSY) & ~flush_in & (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
        if (expire)
            result_d = {{32{sel[31]}}, sel};
    end
    assign busy_out         = (state_q == BUSY) | ((state_q == IDLE) & start_in);
    assign done_out         = (state_q == DONE) & ~flush_in;
    assign result_out       = result_q;
    assign div_dividend_out = dividend_q;
    assign div_divisor_out  = divisor_q;
    assign div_signed_out   = signed_q;
endmodule

// File: tb/tb_div_w_ctrl.sv
// tb_div_w_ctrl: randomized and directed self-checking bench for div_w_ctrl with a behavioural divider.
module tb_div_w_ctrl;
    localparam int LAT = 4;
    logic        clk = 0, rst = 1, start = 0, flush = 0;
    logic [1:0]  op = 0;
    logic [63:0] rs1 = 0, rs2 = 0;
    logic        busy, done, sgn, z;
    logic [63:0] result, dvd, r;
    logic [31:0] dvs, q;
    logic signed [63:0] sd, sv;
    int n_chk = 0, n_fail = 0;

    div_w_ctrl #(.DIV_LATENCY(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start_in(start), .op_in(op), .rs1_in(rs1), .rs2_in(rs2),
        .flush_in(flush), .busy_out(busy), .done_out(done), .result_out(result),
        .div_dividend_out(dvd), .div_divisor_out(dvs), .div_signed_out(sgn),
        .div_quotient_in(q), .div_remainder_in(r), .div_zero_in(z)
    );

    always #5 clk = ~clk;

    // Divider: junk on divide-by-zero and on the unrepresentable +2^31 quotient, so the block must override.
    always_comb begin
        sd = $signed(dvd);
        sv = $signed({{32{dvs[31]}}, dvs});
        z  = (dvs == 32'd0);
        q  = 32'hDEAD_BEEF;
        r  = 64'h0123_4567_89AB_CDEF;
        if (!z) begin
            if (sgn && dvd == 64'hFFFF_FFFF_8000_0000 && dvs == 32'hFFFF_FFFF) begin
                q = 32'h7FFF_FFFF;
                r = 64'h5555;
            end else if (sgn) begin
                q = 32'(sd / sv);
                r = 64'(sd % sv);
            end else begin
                q = 32'(dvd / {32'd0, dvs});
                r = dvd % {32'd0, dvs};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [31:0] a, b, res;
        longint sa, sb;
        a = x[31:0];
        b = y[31:0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0)
            res = o[1] ? a : 32'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            res = o[1] ? 32'd0 : 32'h8000_0000;
        else if (!o[0])
            res = o[1] ? 32'(sa % sb) : 32'(sa / sb);
        else
            res = o[1] ? a % b : a / b;
        return {{32{res[31]}}, res};
    endfunction

    // Issues one op in the current cycle with start held through DONE, then leaves one idle cycle.
    task automatic run_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        int exp_done = LAT + 1;
        int dc = -1;
        int pulses = 0;
        logic bad_busy = 0, bad_ops = 0;
        logic [63:0] exp_dvd;
        exp_dvd = !o[0] ? {{32{x[31]}}, x[31:0]} : {32'd0, x[31:0]};
`ifdef DIV_ZERO_FAST_EN
        if (y[31:0] == 0) exp_done = 1;
`endif
        op = o; rs1 = x; rs2 = y; start = 1;
        #1;
        chk("busy_issue", {63'd0, busy}, 64'd1);
        for (int c = 1; c <= exp_done; c++) begin
            tick();
            if (done) begin
                pulses++;
                if (dc < 0) dc = c;
            end
            if (c < exp_done) begin
                if (!busy) bad_busy = 1;
                if (dvd !== exp_dvd || dvs !== y[31:0] || sgn !== !o[0]) bad_ops = 1;
            end else if (busy) bad_busy = 1;
        end
        tick();
        if (done) pulses++;
        start = 0;
        #1;
        if (busy) bad_busy = 1;
        tick();
        if (done) pulses++;
        chk("done_cycle", 64'(dc), 64'(exp_done));
        chk("done_pulses", 64'(pulses), 64'd1);
        chk("result", result, ref_res(o, x, y));
        chk("busy_seq", {63'd0, bad_busy}, 64'd0);
        chk("div_inputs", {63'd0, bad_ops}, 64'd0);
    endtask

    initial begin
        int cnt;
        logic [63:0] held;
        logic [31:0] a, b;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_divin", {dvd ^ {32'd0, dvs}, 63'd0, sgn} == 0 ? 64'd0 : 64'd1, 64'd0);
        rst = 0;
        tick();
        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2);
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2);
        run_op(2'b01, 64'h1234_5678_FFFF_FFFF, 64'hAAAA_0000_0000_0010);
        run_op(2'b01, 64'h5, 64'h0);
        run_op(2'b10, 64'h8000_0005, 64'h0);
        run_op(2'b00, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op(2'b10, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op(2'b11, 64'hFFFF_0000_8000_0007, 64'h1234_5678_0000_0010);
        // Reset in cycle 2 of a DIVW: everything returns to zero at once and nothing completes later.
        op = 2'b00; rs1 = 64'h64; rs2 = 64'h7; start = 1;
        tick();
        tick();
        rst = 1; start = 0;
        #1;
        chk("midrst_result", result, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_dvd", dvd, 64'd0);
        chk("midrst_dvs", {32'd0, dvs}, 64'd0);
        chk("midrst_sgn", {63'd0, sgn}, 64'd0);
        tick();
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("midrst_quiet", 64'(cnt), 64'd0);
        run_op(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'h7);
        // Flush in cycle 3 of a busy op, then accept a new start the very next cycle.
        held = result;
        op = 2'b00; rs1 = 64'h3E8; rs2 = 64'h3; start = 1;
        tick();
        tick();
        tick();
        flush = 1; start = 0;
        tick();
        flush = 0;
        #1;
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hold", result, held);
        run_op(2'b11, 64'h3E8, 64'h3);
        // Flush in IDLE blocks the simultaneous start.
        held = result;
        op = 2'b00; rs1 = 64'h10; rs2 = 64'h4; start = 1; flush = 1;
        tick();
        start = 0; flush = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("idle_flush_quiet", 64'(cnt), 64'd0);
        chk("idle_flush_hold", result, held);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0: begin a = $urandom(); b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom(); b = $urandom_range(1, 9); end
                3: begin a = $urandom(); b = -$urandom_range(1, 9); end
                default: begin a = $urandom(); b = $urandom(); end
            endcase
            run_op(2'($urandom_range(0, 3)), {32'($urandom()), a}, {32'($urandom()), b});
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/div_w_ctrl.md
Name: div_w_ctrl

Overview:
- Sequencing stage directly upstream of the 64-bit combinational divider in the RV64 CPU.
- Accepts RV64M word divide ops (DIVW/DIVUW/REMW/REMUW), registers and extends the operands, and drives the divider's dividend/divisor/signed-mode inputs.
- Holds those inputs for a fixed multicycle window, then captures the divider's quotient, remainder and zero flag.
- Applies RISC-V special-case semantics, sign-extends the 32-bit result to 64 bits, and stalls the core until the result is valid.

Parameters:
- DIV_LATENCY, 4, cycles the divider inputs are held stable before the result is sampled; legal range 1..255.
- CNT_W, 8, width of the latency counter; must satisfy 2^CNT_W > DIV_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start_in  in  1  request; held high by core while the div instruction is stalled.
- op_in  in  2  00 DIVW, 01 DIVUW, 10 REMW, 11 REMUW; sampled with start_in.
- rs1_in  in  64  source 1; only [31:0] used.
- rs2_in  in  64  source 2; only [31:0] used.
- flush_in  in  1  abort in-flight op.
- busy_out  out  1  stall request to PC/writeback.
- done_out  out  1  one-cycle result-valid pulse.
- result_out  out  64  registered, sign-extended result.
- div_dividend_out  out  64  to divider dividend.
- div_divisor_out  out  32  to divider divisor.
- div_signed_out  out  1  to divider signed-mode select.
- div_quotient_in  in  32  from divider.
- div_remainder_in  in  64  from divider.
- div_zero_in  in  1  divide-by-zero flag from divider.

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, result_out 0, done_out 0, operand registers 0. Hence div_dividend_out, div_divisor_out and div_signed_out are all 0.
- Reset applies at any point, including mid-operation; no partial result is ever emitted afterwards.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On start_in=1, latch the operands:
    - signed = ~op_in[0];
    - dividend = signed ? sign-extend rs1_in[31:0] : zero-extend rs1_in[31:0];
    - divisor = rs2_in[31:0];
    - is_rem = op_in[1].
  - Load counter = DIV_LATENCY-1 and go to BUSY.
- BUSY:
  - Divider inputs are driven only from the operand registers and stay stable throughout.
  - If counter != 0, decrement.
  - If counter == 0, capture the result into result_out and go to DONE.
- DONE:
  - done_out=1 for exactly this cycle; result_out is valid and held until the next capture.
  - start_in is ignored in this cycle, because it is still the retiring instruction. The next state is always IDLE.
- busy_out = (state==BUSY) | (state==IDLE & start_in). The core therefore stalls in the issue cycle without a bubble.
- Latency: with start_in in cycle 0, done_out is high in cycle DIV_LATENCY+1.
- Result formation, where q = div_quotient_in and r = div_remainder_in[31:0]:
  - div_zero_in=1: quotient = 0xFFFFFFFF and remainder = dividend[31:0]. The divider's outputs are ignored.
  - Signed, dividend[31:0]=0x80000000 and divisor=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Otherwise: quotient = q, remainder = r.
  - result_out = sign-extend of (is_rem ? remainder : quotient). This applies to the unsigned ops too, per RV64 W semantics.
- flush_in=1 in BUSY or DONE:
  - Go to IDLE next edge; result_out is unchanged and done_out is not pulsed.
  - flush has priority over counter expiry.
  - flush_in in IDLE blocks acceptance of start_in in that cycle.
- rs1_in[63:32] and rs2_in[63:32] never affect any output.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- When defined: in IDLE, if start_in=1 and rs2_in[31:0]==0, latch the operands, skip BUSY and go directly to DONE. On that edge, result_out gets the divide-by-zero result computed from rs1_in and op_in. done_out is then high in cycle 1, and busy_out is high only in cycle 0.
- When undefined: a zero divisor takes the full DIV_LATENCY path, and the result uses div_zero_in.

Test Plan (bench instantiates the existing divider behind this block, DIV_LATENCY=4):
- DIVW, rs1=0xFFFFFFFF_FFFFFFF9, rs2=0x2 -> done_out in cycle 5, result_out=0xFFFFFFFF_FFFFFFFD; busy_out high cycles 0-4. The same operands with REMW -> 0xFFFFFFFF_FFFFFFFF.
- DIVUW, rs1=0x12345678_FFFFFFFF, rs2=0xAAAA0000_00000010 -> result_out=0x00000000_0FFFFFFF. This also proves the upper bits are ignored.
- Divide by zero:
  - DIVUW, rs1=5, rs2=0 -> 0xFFFFFFFF_FFFFFFFF.
  - REMW, rs1=0x80000005, rs2=0 -> 0xFFFFFFFF_80000005.
  - Done cycle is 5 without DIV_ZERO_FAST_EN and 1 with it.
- Overflow: DIVW, rs1=0x80000000, rs2=0xFFFFFFFF -> 0xFFFFFFFF_80000000; REMW with the same operands -> 0.
- start_in held high through DONE -> exactly one done_out pulse. Back-to-back DIVW then REMUW (start deasserted one cycle in between) -> two results, each DIV_LATENCY+1 cycles after its start.
- rst asserted in cycle 2 of a DIVW -> all outputs 0 immediately. flush_in in cycle 3 -> no done_out, result_out unchanged, and IDLE accepts a new start the following cycle.
